fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 16-bit pipelined CPU. It owns the PC and drives the synchronous

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 16 +
 rtl/fetch_hold_buf.sv | 46 ++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 120 ++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_W          : instruction / address width
//   fetch_state_t    : fetch FSM states (RUN = streaming, HOLD = instruction parked in hold buffer)
//   pc_inc / pc_even : address helpers (wrap modulo 2^16, force halfword alignment)
package cpu_pkg;

  localparam int unsigned     INSTR_W          = 16;
  localparam logic [15:0]     RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  // Next sequential instruction address; FFFE wraps to 0000 with no flag.
  function automatic logic [INSTR_W-1:0] pc_inc(input logic [INSTR_W-1:0] addr);
    return addr + 16'h0002;
  endfunction

  // Instructions are halfword aligned, so bit 0 of any redirect target is dropped.
  function automatic logic [INSTR_W-1:0] pc_even(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port used by the fetch stage.
//   pc_addr   : read address (byte address, even)
//   pc_rd     : read strobe; data returned on pc_rddata one cycle later
//   pc_rddata : read data
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0] pc_addr;
  logic               pc_rd;
  logic [INSTR_W-1:0] pc_rddata;

  modport master (output pc_addr, output pc_rd, input pc_rddata);
  modport slave  (input pc_addr, input pc_rd, output pc_rddata);

endinterface

// File: rtl/fetch_hold_buf.sv
// Hold buffer for the fetch stage: parks the fetched word when decode stalls and
// selects what is presented on o_ir.
//   clk, reset   : clock, synchronous active-high reset
//   i_capture    : load i_rddata into the hold register this cycle
//   i_hold_sel   : present the held word (FSM in HOLD)
//   i_rd         : a read was issued last cycle, so i_rddata is meaningful
//   i_rddata     : instruction-memory read data
//   o_ir         : instruction presented to decode
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_capture,
  input  logic               i_hold_sel,
  input  logic               i_rd,
  input  logic [INSTR_W-1:0] i_rddata,
  output logic [INSTR_W-1:0] o_ir
);

  logic [INSTR_W-1:0] r_hold_ir;

  // Hold register: cleared on reset so a parked word cannot survive it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_ir <= 16'h0000;
    end else if (i_capture) begin
      r_hold_ir <= i_rddata;
    end else begin
      r_hold_ir <= r_hold_ir;
    end
  end

  // o_ir select; memory data is only trusted when a read was actually issued.
  always_comb begin
    o_ir = 16'h0000;
    if (i_hold_sel) begin
      o_ir = r_hold_ir;
    end else if (i_rd) begin
      o_ir = i_rddata;
    end else begin
      o_ir = 16'h0000;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read port and
// presents the fetched instruction plus its PC+2 to decode / the branch resolver.
// Redirects steer the address issued in the same cycle, so they cost no bubble.
//   clk, reset          : clock, synchronous active-high reset
//   i_stall             : decode cannot accept o_ir this cycle
//   i_branch_sig        : instruction on o_ir redirects the PC
//   i_pc_to_be_jumped   : redirect target
//   imem                : instruction-memory read port (master side)
//   o_ir                : instruction presented to decode
//   o_pc_plus_2         : address of o_ir + 2
//   o_valid             : o_ir / o_pc_plus_2 hold a real instruction
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_stall,
  input  logic               i_branch_sig,
  input  logic [INSTR_W-1:0] i_pc_to_be_jumped,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] o_ir,
  output logic [INSTR_W-1:0] o_pc_plus_2,
  output logic               o_valid
);

  fetch_state_t       r_st, w_st_nxt;
  logic [INSTR_W-1:0] r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_fpc, w_fpc_nxt;
  logic               r_rd, w_rd_nxt;
  logic               w_capture;
  logic               w_valid;
  logic               w_issue;
  logic               w_br;
  logic [INSTR_W-1:0] w_addr;

  // State register for PC, in-flight address, read-pending flag and FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st  <= RUN;
      r_pc  <= RESET_PC;
      r_fpc <= 16'h0000;
      r_rd  <= 1'b0;
    end else begin
      r_st  <= w_st_nxt;
      r_pc  <= w_pc_nxt;
      r_fpc <= w_fpc_nxt;
      r_rd  <= w_rd_nxt;
    end
  end

  // Next-state, issue address and capture decisions.
  always_comb begin
    w_st_nxt  = r_st;
    w_pc_nxt  = r_pc;
    w_fpc_nxt = r_fpc;
    w_rd_nxt  = r_rd;
    w_capture = 1'b0;

    w_valid = ~reset & ((r_st == HOLD) | r_rd);
    w_issue = ~reset & ~i_stall;
    // A branch only counts against a real instruction, and is ignored while stalled:
    // the resolver re-evaluates the same instruction when the stall drops.
    w_br    = i_branch_sig & w_valid;

    if (reset) begin
      w_addr = RESET_PC;
    end else if (w_issue & w_br) begin
      w_addr = pc_even(i_pc_to_be_jumped);
    end else begin
      w_addr = r_pc;
    end

    if (reset) begin
      w_st_nxt  = RUN;
      w_pc_nxt  = RESET_PC;
      w_fpc_nxt = 16'h0000;
      w_rd_nxt  = 1'b0;
    end else if (!i_stall) begin
      // Issue; in HOLD this also consumes the parked instruction.
      w_pc_nxt  = pc_inc(w_addr);
      w_fpc_nxt = w_addr;
      w_rd_nxt  = 1'b1;
      w_st_nxt  = RUN;
    end else begin
      w_rd_nxt = 1'b0;
      case (r_st)
        RUN: begin
          if (w_valid) begin
            // Memory data is only present this cycle; park it before it disappears.
            w_capture = 1'b1;
            w_st_nxt  = HOLD;
          end else begin
            w_st_nxt  = RUN;
          end
        end
        HOLD:    w_st_nxt = HOLD;
        default: w_st_nxt = RUN;
      endcase
    end
  end

  // Output drive; everything is forced to its idle value while reset is high.
  always_comb begin
    imem.pc_addr = w_addr;
    imem.pc_rd   = w_issue;
    o_valid      = w_valid;
    if (reset) begin
      o_pc_plus_2 = 16'h0002;
    end else begin
      o_pc_plus_2 = pc_inc(r_fpc);
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .i_capture  (w_capture),
    .i_hold_sel (~reset & (r_st == HOLD)),
    .i_rd       (~reset & r_rd),
    .i_rddata   (imem.pc_rddata),
    .o_ir       (o_ir)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        i_stall;
  logic        i_branch_sig;
  logic [15:0] i_pc_to_be_jumped;
  logic [15:0] o_ir;
  logic [15:0] o_pc_plus_2;
  logic        o_valid;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_stall           (i_stall),
    .i_branch_sig      (i_branch_sig),
    .i_pc_to_be_jumped (i_pc_to_be_jumped),
    .imem              (imem.master),
    .o_ir              (o_ir),
    .o_pc_plus_2       (o_pc_plus_2),
    .o_valid           (o_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word = its address, except 0006 holds 1234.
  // When no read is issued the data bus carries changing junk.
  logic [15:0] junk_cnt = 16'h0000;
  always @(posedge clk) begin
    junk_cnt <= junk_cnt + 16'h0001;
    if (imem.pc_rd) begin
      imem.pc_rddata <= (imem.pc_addr == 16'h0006) ? 16'h1234 : imem.pc_addr;
    end else begin
      imem.pc_rddata <= 16'hDEAD ^ junk_cnt;
    end
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] addr;
    logic        rd;
    logic        valid;
    logic [15:0] ir;
    logic [15:0] p2;
  } vec_t;

  vec_t vecs[26];

  initial begin
    //           rst   stall br    tgt       addr      rd    valid ir        p2
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0002};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0002};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0002};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b1, 16'h0000, 16'h0002};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 1'b1, 16'h0002, 16'h0004};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 1'b1, 16'h0004, 16'h0006};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1, 16'h1234, 16'h0008};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1, 16'h1234, 16'h0008};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1, 16'h1234, 16'h0008};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 1'b1, 16'h1234, 16'h0008};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h000A, 1'b1, 1'b1, 16'h0008, 16'h000A};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h000C, 1'b1, 1'b1, 16'h000A, 16'h000C};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h000E, 1'b1, 1'b1, 16'h000C, 16'h000E};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0040, 16'h0040, 1'b1, 1'b1, 16'h000E, 16'h0010};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0042, 1'b1, 1'b1, 16'h0040, 16'h0042};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 16'h0080, 16'h0044, 1'b0, 1'b1, 16'h0042, 16'h0044};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 16'h0080, 16'h0044, 1'b0, 1'b1, 16'h0042, 16'h0044};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 16'h0080, 16'h0080, 1'b1, 1'b1, 16'h0042, 16'h0044};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0082, 1'b1, 1'b1, 16'h0080, 16'h0082};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0084, 1'b0, 1'b1, 16'h0082, 16'h0084};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0084, 1'b0, 1'b1, 16'h0082, 16'h0084};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0002};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0002};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 1'b1, 1'b1, 16'h0000, 16'h0002};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 16'h0000};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b1, 16'h0000, 16'h0002};

    reset             = 1'b1;
    i_stall           = 1'b0;
    i_branch_sig      = 1'b0;
    i_pc_to_be_jumped = 16'h0000;

    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1;
      reset             = vecs[i].rst;
      i_stall           = vecs[i].stall;
      i_branch_sig      = vecs[i].br;
      i_pc_to_be_jumped = vecs[i].tgt;
      #2;
      check_val($sformatf("c%0d addr", i),  imem.pc_addr,        vecs[i].addr);
      check_val($sformatf("c%0d rd", i),    {15'd0, imem.pc_rd}, {15'd0, vecs[i].rd});
      check_val($sformatf("c%0d valid", i), {15'd0, o_valid},    {15'd0, vecs[i].valid});
      check_val($sformatf("c%0d ir", i),    o_ir,                vecs[i].ir);
      check_val($sformatf("c%0d pc+2", i),  o_pc_plus_2,         vecs[i].p2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
